// File: rtl/midi_rx_fifo.sv
// midi_rx_fifo: oversampling MIDI receiver with running-status tagging and an
// output FIFO. Realtime bytes (F8-FF) bypass the FIFO on rt_valid/rt_data.
// Ports:
//   CLOCK_25, iRST_N      clock, async active-low reset
//   midi_rxd              raw serial line (idles high, asynchronous)
//   m_ready/m_valid       FIFO pop handshake; m_data/m_status/m_idx = head entry
//   rt_valid/rt_data      realtime byte pulse and held value
//   frame_err             pulse on low stop bit
//   overflow/ovf_clr      sticky drop flag and its clear
//   fifo_level            current occupancy

package midi_rx_fifo_pkg;
  typedef struct packed {
    logic [7:0] data;
    logic [7:0] status;
    logic [7:0] idx;
  } midi_entry_t;
endpackage

module midi_rx_fifo
  import midi_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned BAUD       = 31250,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_25,
  input  logic                          iRST_N,
  input  logic                          midi_rxd,
  input  logic                          m_ready,
  input  logic                          ovf_clr,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  output logic [7:0]                    m_status,
  output logic [7:0]                    m_idx,
  output logic                          rt_valid,
  output logic [7:0]                    rt_data,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS    = OVERSAMPLE;
  localparam int unsigned HALF  = OS / 2;
  localparam int unsigned CNT_W = $clog2(OS + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_t;

  // Two-flop synchroniser plus previous-sample register for edge detection
  logic rx_meta, rx_s, rx_prev, fall;
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= midi_rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end
  assign fall = rx_prev & ~rx_s;

  // Oversampling tick generator, realigned to each start edge
  logic [DIV_W-1:0] div_cnt;
  logic             tick, restart;
  assign tick = (div_cnt == DIV_W'(DIV - 1));
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N)      div_cnt <= '0;
    else if (restart) div_cnt <= '0;
    else if (tick)    div_cnt <= '0;
    else              div_cnt <= div_cnt + DIV_W'(1);
  end

  // Receiver FSM state and datapath registers
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       sh, sh_n;
  logic [1:0]       votes, votes_n, vote_sum;
  logic             maj, done_c, ferr_c;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign vote_sum = votes + {1'b0, rx_s};
  assign maj      = vote_sum[1];

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      votes   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      votes   <= votes_n;
    end
  end

  // Next-state logic; samples are taken at window ticks HALF-1, HALF, HALF+1
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    votes_n = votes;
    done_c  = 1'b0;
    ferr_c  = 1'b0;
    restart = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          restart = 1'b1;
          cnt_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_W'(HALF) && rx_s) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else if (cnt_inc == CNT_W'(OS)) begin
            cnt_n   = '0;
            bit_n   = '0;
            state_n = S_DATA;
          end
        end
      end
      S_DATA, S_STOP: begin
        if (tick) begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_W'(HALF - 1)) begin
            votes_n = {1'b0, rx_s};
          end else if (cnt_inc == CNT_W'(HALF)) begin
            votes_n = vote_sum;
          end else if (cnt_inc == CNT_W'(HALF + 1)) begin
            if (state == S_DATA) begin
              sh_n = {maj, sh[7:1]};
            end else begin
              cnt_n   = '0;
              done_c  = maj;
              ferr_c  = ~maj;
              state_n = maj ? S_IDLE : S_BREAK;
            end
          end else if (cnt_inc == CNT_W'(OS)) begin
            cnt_n = '0;
            if (bit_idx == 3'd7) state_n = S_STOP;
            else                 bit_n   = bit_idx + 3'd1;
          end
        end
      end
      S_BREAK: begin
        // Line must stay high for a whole bit time before re-arming
        if (!rx_s) begin
          cnt_n = '0;
        end else if (tick) begin
          if (cnt_inc == CNT_W'(OS)) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Completion stage: realtime bypass, framing pulse, byte hand-off to parser
  logic       is_rt, rx_done;
  logic [7:0] rx_byte;
  assign is_rt = (sh[7:3] == 5'h1F);
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      rt_valid  <= 1'b0;
      rt_data   <= '0;
      frame_err <= 1'b0;
      rx_done   <= 1'b0;
      rx_byte   <= '0;
    end else begin
      rt_valid  <= done_c & is_rt;
      frame_err <= ferr_c;
      rx_done   <= done_c & ~is_rt;
      if (done_c && is_rt)  rt_data <= sh;
      if (done_c && !is_rt) rx_byte <= sh;
    end
  end

  // Data bytes expected after a status byte; 0 means unbounded
  function automatic logic [1:0] msg_len(input logic [7:0] s);
    case (s[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: msg_len = 2'd2;
      4'hC, 4'hD:                   msg_len = 2'd1;
      4'hF: begin
        case (s[3:0])
          4'h2:       msg_len = 2'd2;
          4'h1, 4'h3: msg_len = 2'd1;
          default:    msg_len = 2'd0;
        endcase
      end
      default: msg_len = 2'd0;
    endcase
  endfunction

  // Running-status parser
  logic [7:0]  cur_status, status_n, run_idx, idx_n;
  logic [1:0]  len;
  midi_entry_t entry;
  assign len = msg_len(cur_status);

  always_comb begin
    status_n = cur_status;
    idx_n    = run_idx;
    entry    = '0;
    if (rx_byte[7]) begin
      idx_n = '0;
      if (rx_byte[7:4] != 4'hF)      status_n = rx_byte;
      else if (rx_byte[3:2] == 2'b00) status_n = rx_byte;
      else                            status_n = '0;
      entry = '{data: rx_byte, status: rx_byte, idx: 8'h00};
    end else begin
      if (len != 2'd0 && run_idx == {6'b0, len}) idx_n = 8'd1;
      else if (run_idx == 8'hFF)                 idx_n = 8'hFF;
      else                                       idx_n = run_idx + 8'd1;
      entry = '{data: rx_byte, status: cur_status, idx: idx_n};
    end
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      cur_status <= '0;
      run_idx    <= '0;
    end else if (rx_done) begin
      cur_status <= status_n;
      run_idx    <= idx_n;
    end
  end

  // FIFO with registered fall-through head
  midi_entry_t     mem [FIFO_DEPTH];
  midi_entry_t     head_n;
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_n;
  logic [LW-1:0]   level_n;
  logic            full, pop, push_ok;

  assign full    = (fifo_level == LW'(FIFO_DEPTH));
  assign pop     = m_valid & m_ready;
  assign push_ok = rx_done & (~full | pop);
  assign rd_n    = pop ? rd_ptr + AW'(1) : rd_ptr;
  // Bypass the entry being written when it becomes the new head
  assign head_n  = (push_ok && rd_n == wr_ptr) ? entry : mem[rd_n];

  always_comb begin
    level_n = fifo_level;
    case ({push_ok, pop})
      2'b10:   level_n = fifo_level + LW'(1);
      2'b01:   level_n = fifo_level - LW'(1);
      default: level_n = fifo_level;
    endcase
  end

  always_ff @(posedge CLOCK_25) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_status   <= '0;
      m_idx      <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_n;
      fifo_level <= level_n;
      m_valid    <= (level_n != '0);
      if (level_n != '0) begin
        m_data   <= head_n.data;
        m_status <= head_n.status;
        m_idx    <= head_n.idx;
      end
      if (rx_done && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)            overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_midi_rx_fifo.sv
// Testbench for midi_rx_fifo: serial byte driver, scoreboard of expected
// FIFO entries checked on every pop, plus per-scenario inline checks.
module tb_midi_rx_fifo;

  localparam int unsigned CLK_HZ   = 2_000_000;
  localparam int unsigned BAUD     = 31250;
  localparam int unsigned OS       = 16;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned DIV      = CLK_HZ / (BAUD * OS);
  localparam int unsigned BIT_CLKS = DIV * OS;
  localparam int unsigned LW       = $clog2(DEPTH) + 1;

  logic          CLOCK_25;
  logic          iRST_N;
  logic          midi_rxd;
  logic          m_ready;
  logic          ovf_clr;
  logic          m_valid;
  logic [7:0]    m_data, m_status, m_idx;
  logic          rt_valid;
  logic [7:0]    rt_data;
  logic          frame_err;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  int rt_cnt   = 0;
  int ferr_cnt = 0;
  logic [23:0] exp_q[$];

  midi_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLOCK_25(CLOCK_25), .iRST_N(iRST_N), .midi_rxd(midi_rxd),
    .m_ready(m_ready), .ovf_clr(ovf_clr), .m_valid(m_valid),
    .m_data(m_data), .m_status(m_status), .m_idx(m_idx),
    .rt_valid(rt_valid), .rt_data(rt_data), .frame_err(frame_err),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  initial CLOCK_25 = 1'b0;
  always #5 CLOCK_25 = ~CLOCK_25;

  // Scoreboard: every accepted head entry is compared with the oldest expectation
  always @(negedge CLOCK_25) begin
    if (iRST_N && m_valid && m_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_pop unexpected entry got %h/%h/%h", m_data, m_status, m_idx);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({m_data, m_status, m_idx} !== e)
          begin
            n_fail++;
            $display("FAIL fifo_pop got %h/%h/%h want %h/%h/%h",
                     m_data, m_status, m_idx, e[23:16], e[15:8], e[7:0]);
          end
      end
    end
  end

  // Pulse counters for the one-cycle outputs
  always @(negedge CLOCK_25) begin
    if (rt_valid)  rt_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge CLOCK_25);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    midi_rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      midi_rxd = b[i];
      wait_clks(BIT_CLKS);
    end
    midi_rxd = stop_val;
    wait_clks(BIT_CLKS);
  endtask

  task automatic expect_entry(input logic [7:0] d, input logic [7:0] s, input logic [7:0] i);
    exp_q.push_back({d, s, i});
  endtask

  task automatic test_reset;
    iRST_N = 1'b0; midi_rxd = 1'b1; m_ready = 1'b0; ovf_clr = 1'b0;
    wait_clks(5);
    n_checks++;
    if ({m_valid, m_data, m_status, m_idx, rt_valid, rt_data, frame_err, overflow, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h s=%h i=%h rt=%b/%h fe=%b ov=%b lvl=%0d want all 0",
               m_valid, m_data, m_status, m_idx, rt_valid, rt_data, frame_err, overflow, fifo_level);
    end
    iRST_N = 1'b1;
    wait_clks(2 * BIT_CLKS);
  endtask

  task automatic test_note_on;
    int fe0;
    fe0 = ferr_cnt;
    m_ready = 1'b1;
    expect_entry(8'h90, 8'h90, 8'h00);
    expect_entry(8'h3C, 8'h90, 8'h01);
    expect_entry(8'h64, 8'h90, 8'h02);
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    wait_clks(2 * BIT_CLKS);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL note_on_missing got %0d left want 0", exp_q.size()); end
    n_checks++;
    if (ferr_cnt !== fe0) begin n_fail++; $display("FAIL note_on_frame_err got %0d want %0d", ferr_cnt, fe0); end
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h64) begin
      n_fail++; $display("FAIL note_on_hold got v=%b d=%h want v=0 d=64", m_valid, m_data);
    end
  endtask

  task automatic test_running_status;
    logic [7:0] bytes [5];
    bytes = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h50};
    expect_entry(8'h90, 8'h90, 8'h00);
    expect_entry(8'h3C, 8'h90, 8'h01);
    expect_entry(8'h64, 8'h90, 8'h02);
    expect_entry(8'h3E, 8'h90, 8'h01);
    expect_entry(8'h50, 8'h90, 8'h02);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    wait_clks(2 * BIT_CLKS);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL running_missing got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_realtime;
    int rt0;
    rt0 = rt_cnt;
    expect_entry(8'h90, 8'h90, 8'h00);
    expect_entry(8'h3C, 8'h90, 8'h01);
    expect_entry(8'h64, 8'h90, 8'h02);
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1);
    send_byte(8'hF8, 1'b1); send_byte(8'h64, 1'b1);
    wait_clks(2 * BIT_CLKS);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rt_missing got %0d left want 0", exp_q.size()); end
    n_checks++;
    if (rt_cnt !== rt0 + 1) begin n_fail++; $display("FAIL rt_pulses got %0d want %0d", rt_cnt - rt0, 1); end
    n_checks++;
    if (rt_data !== 8'hF8) begin n_fail++; $display("FAIL rt_data got %h want f8", rt_data); end
  endtask

  task automatic test_framing;
    int fe0;
    fe0 = ferr_cnt;
    send_byte(8'h55, 1'b0);
    wait_clks(4000);
    n_checks++;
    if (ferr_cnt !== fe0 + 1) begin n_fail++; $display("FAIL frame_err_pulses got %0d want 1", ferr_cnt - fe0); end
    n_checks++;
    if (fifo_level !== '0) begin n_fail++; $display("FAIL frame_queued got lvl=%0d want 0", fifo_level); end
    midi_rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
    expect_entry(8'h90, 8'h90, 8'h00);
    send_byte(8'h90, 1'b1);
    wait_clks(2 * BIT_CLKS);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL after_break_missing got %0d left want 0", exp_q.size()); end
    midi_rxd = 1'b0;
    wait_clks(10);
    midi_rxd = 1'b1;
    wait_clks(3 * BIT_CLKS);
    n_checks++;
    if (m_valid !== 1'b0 || fifo_level !== '0 || ferr_cnt !== fe0 + 1) begin
      n_fail++;
      $display("FAIL glitch got v=%b lvl=%0d fe=%0d want v=0 lvl=0 fe=1", m_valid, fifo_level, ferr_cnt - fe0);
    end
  endtask

  task automatic test_system;
    logic [7:0] bytes [8];
    bytes = '{8'hF2, 8'h01, 8'h02, 8'hF0, 8'h01, 8'h02, 8'h03, 8'hF7};
    expect_entry(8'hF2, 8'hF2, 8'h00);
    expect_entry(8'h01, 8'hF2, 8'h01);
    expect_entry(8'h02, 8'hF2, 8'h02);
    expect_entry(8'hF0, 8'hF0, 8'h00);
    expect_entry(8'h01, 8'hF0, 8'h01);
    expect_entry(8'h02, 8'hF0, 8'h02);
    expect_entry(8'h03, 8'hF0, 8'h03);
    expect_entry(8'hF7, 8'hF7, 8'h00);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    wait_clks(2 * BIT_CLKS);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL system_missing got %0d left want 0", exp_q.size()); end
    n_checks++;
    if ({m_data, m_status, m_idx} !== 24'hF7F700) begin
      n_fail++; $display("FAIL system_hold got %h/%h/%h want f7/f7/00", m_data, m_status, m_idx);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] bytes [9];
    bytes = '{8'h90, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    m_ready = 1'b0;
    expect_entry(8'h90, 8'h90, 8'h00);
    for (int i = 1; i < 8; i++) expect_entry(8'(i), 8'h90, (i % 2 == 1) ? 8'h01 : 8'h02);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    wait_clks(10);
    n_checks++;
    if (fifo_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_level got %0d want %0d", fifo_level, DEPTH); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    ovf_clr = 1'b1;
    wait_clks(1);
    ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", overflow); end
    m_ready = 1'b1;
    wait_clks(20);
    n_checks++;
    if (exp_q.size() !== 0 || fifo_level !== '0) begin
      n_fail++; $display("FAIL ovf_drain got left=%0d lvl=%0d want 0/0", exp_q.size(), fifo_level);
    end
  endtask

  task automatic test_reset_mid_frame;
    m_ready = 1'b0;
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1);
    wait_clks(BIT_CLKS);
    n_checks++;
    if (fifo_level !== LW'(2)) begin n_fail++; $display("FAIL pre_reset_level got %0d want 2", fifo_level); end
    midi_rxd = 1'b0;
    wait_clks(3 * BIT_CLKS);
    iRST_N = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, m_data, m_status, m_idx, rt_valid, rt_data, frame_err, overflow, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got v=%b d=%h s=%h i=%h rt=%b/%h fe=%b ov=%b lvl=%0d want all 0",
               m_valid, m_data, m_status, m_idx, rt_valid, rt_data, frame_err, overflow, fifo_level);
    end
    midi_rxd = 1'b1;
    wait_clks(5);
    iRST_N = 1'b1;
    wait_clks(2 * BIT_CLKS);
    m_ready = 1'b1;
    expect_entry(8'hC0, 8'hC0, 8'h00);
    expect_entry(8'h05, 8'hC0, 8'h01);
    expect_entry(8'h07, 8'hC0, 8'h01);
    send_byte(8'hC0, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h07, 1'b1);
    wait_clks(2 * BIT_CLKS);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL post_reset_missing got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_framing();
    test_system();
    test_overflow();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_rx_fifo.md
# midi_rx_fifo

Parametrised MIDI serial receiver for the synthesizer front end. It oversamples `midi_rxd` and rejects glitches and framing errors. Realtime bytes (F8–FF) go straight to a dedicated bypass port. All other bytes are tagged with the running status and their position in the message, then queued in a FIFO. Downstream voice/controller logic pops them through a valid/ready handshake.

## Interface
- `CLK_HZ`, 25_000_000, system clock frequency.
- `BAUD`, 31250, MIDI bit rate.
- `OVERSAMPLE`, 16, ticks per bit; even, at least 8.
- `FIFO_DEPTH`, 8, entries; power of two, at least 2.
- `CLOCK_25` input 1: system clock; all logic runs on its rising edge.
- `iRST_N` input 1: asynchronous, active-low reset.
- `midi_rxd` input 1: raw serial line; idles high; asynchronous to the clock.
- `m_ready` input 1: consumer accepts the head entry.
- `ovf_clr` input 1: single-cycle pulse that clears `overflow`.
- `m_valid` output 1: FIFO head is valid.
- `m_data` output 8: head byte.
- `m_status` output 8: status byte in force when the head byte arrived; 00 means none.
- `m_idx` output 8: 0 for a status byte, 1..N for data-byte position.
- `rt_valid` output 1: one-cycle pulse; a realtime byte was received.
- `rt_data` output 8: the realtime byte; holds until the next realtime byte.
- `frame_err` output 1: one-cycle pulse; stop bit was sampled low.
- `overflow` output 1: sticky; a byte was dropped because the FIFO was full.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **Input sync:** 2-flop synchroniser on `midi_rxd`, reset to 1.
- **Tick generator:** `DIV = CLK_HZ/(BAUD*OVERSAMPLE)`, truncated; default 50. It emits a one-cycle `tick` every `DIV` clocks and is restarted (count 0) on start-edge detection.
- **Receiver FSM:**
  - **IDLE:** on a synced high→low edge, restart the tick generator, clear the tick count and go to START.
  - **START:** at tick OS/2, if the line is still low go to DATA (bit 0); otherwise it was a glitch, return to IDLE.
  - **DATA:** each bit is the majority of 3 samples at ticks OS/2-1, OS/2 and OS/2+1 within the bit window. Bits arrive LSB first; after bit 7 go to STOP.
  - **STOP:** majority sample at the window centre.
    - High: byte complete, go to IDLE.
    - Low: pulse `frame_err`, discard the byte, go to BREAK.
  - **BREAK:** wait for the synced line to be high for one full bit time (OS ticks), then go to IDLE.
- **Classification** of a completed byte `b`:
  - F8–FF: pulse `rt_valid`, load `rt_data`. Not queued; parser state unchanged.
  - 80–EF: `cur_status = b`, `idx = 0`; queue `{b, b, 0}` as data, status, idx.
  - F0–F7: queue `{b, b, 0}`.
    - Then `cur_status` = F0 if `b` = F0; `cur_status` = F1/F2/F3 if `b` is F1/F2/F3, so their data bytes are indexed; otherwise 00.
    - F7 and F6 leave 00.
  - 00–7F: `idx` increments. Then:
    - If `len(cur_status)` > 0 and the previous idx equals `len`, `idx` restarts at 1 (running status).
    - `len`: 8x/9x/Ax/Bx/Ex/F2 → 2; Cx/Dx/F1/F3 → 1.
    - F0 or 00 → unbounded; idx saturates at FF.
    - Queue `{b, cur_status, idx}`.
- **FIFO:**
  - 24-bit entries, first-word fall-through.
  - Pop when `m_valid && m_ready`.
  - Push when full without a same-cycle pop: entry dropped, `overflow` set. Parser state still advances.
  - Simultaneous push and pop when full: both succeed.
  - `ovf_clr` clears `overflow`; if an overflow occurs in the same cycle, set wins.
- **Reset:**
  - All outputs go to 0; FIFO empty; `cur_status` and `idx` cleared; FSM in IDLE.
  - Reset mid-frame abandons the frame; the next falling edge is treated as a start bit.

## Timing
- Default bit time is 800 clocks; tick period is 50 clocks.
- Byte completion is the clock of the stop-bit majority decision (tick OS/2+1 of the stop window).
  - `rt_valid` and `frame_err` pulse 1 cycle after completion.
  - The FIFO write happens 1 cycle after completion.
  - `m_valid`, `m_data`, `m_status` and `m_idx` are valid 2 cycles after completion when the FIFO was empty.
- From `midi_rxd` falling edge to byte completion: 2 sync cycles + 9.5 bit times + 1 tick, ±1 `DIV`.
- Back-to-back bytes (stop bit immediately followed by a start bit) are received without loss.
- `fifo_level` updates in the cycle after a push or pop. `m_valid` drops in the cycle after popping the last entry.
- `m_data` holds its last value while empty.

## Test plan
- **Note-on:** send 90 3C 64, `m_ready`=1 → three entries {90,90,00}, {3C,90,01}, {64,90,02}; no `frame_err`.
- **Running status:** send 90 3C 64 3E 50 → the 4th and 5th entries are {3E,90,01} and {50,90,02}.
- **Realtime interleave:** send F8 between 3C and 64 → `rt_valid` pulses once with `rt_data`=F8; the FIFO holds only the three note bytes, with idx unchanged.
- **Framing:** drive the stop bit low on byte 55 → `frame_err` pulses once; nothing queued. Line held low for 2 ms, then 90 sent → correct entry; a 10-clock low glitch produces no byte.
- **Overflow:** `m_ready`=0, send 9 bytes with `FIFO_DEPTH`=8 → `fifo_level`=8, `overflow`=1, entries are bytes 1–8. Then pulse `ovf_clr` → `overflow`=0.
- **Reset:** assert `iRST_N` mid-byte → all outputs 0 within 1 cycle. After release, C0 05 → {C0,C0,00}, {05,C0,01}; a following 07 → {07,C0,01}.
